prim_alert_sender_sync: RTL and testbench
=========================================

// Module: prim_alert_sender_sync
// PURPOSE
//  Alert-source side of the differential alert link: converts a local alert request into
//  the alert_p/alert_n 4-phase handshake and answers ping toggles from the alert receiver.
//  Sits directly upstream of the receiver: drives alert_tx_o, consumes alert_rx_o.
//  Single clock domain, synchronous active-high reset.
// PARAMETERS
//  PAUSE_CYCLES  2  idle cycles after each handshake before the next may start; legal range >=1
// PORTS
//  clk_i         in   1  clock
//  rst_i         in   1  synchronous reset, active-high
//  alert_req_i   in   1  local alert request; level or pulse, latched
//  alert_ack_o   out  1  1-cycle pulse when an alert (not ping) handshake completes
//  integ_fail_o  out  1  high while the ping or ack pair on alert_rx_i is non-complementary
//  alert_rx_i    in   4  [3]=ping_p [2]=ping_n [1]=ack_p [0]=ack_n
//  alert_tx_o    out  2  [1]=alert_p [0]=alert_n; registered
// BEHAVIOUR
//  Reset values: alert_tx_o=2'b01, alert_ack_o=0, integ_fail_o=0, state=Idle,
//   alert_pend=0, ping_pend=0, ping_prev=0. Reset mid-handshake aborts; tx=01 the next cycle.
//  Input path: alert_rx_i is registered once (rx_q), then decoded per pair:
//   level=p, sigint=(p==n).
//  Ping event: ping level != ping_prev while ping pair is clean; ping_prev updates every clean cycle.
//  Pending flags: alert_pend |= alert_req_i; ping_pend |= ping event.
//   Repeat events while pending merge into one request (no counting).
//  FSM states:
//   Idle     : if ping_pend -> HsPh1 (type=ping, clear ping_pend);
//              else if alert_pend|alert_req_i -> HsPh1 (type=alert, clear alert_pend).
//              Ping wins so the receiver never mis-reads a real alert as ping_ok; alert stays pending.
//   HsPh1    : tx=10; when ack level=1 -> HsPh2.
//   HsPh2    : tx=01; when ack level=0 -> Pause; pulse alert_ack_o if type=alert.
//   Pause    : tx=01 for PAUSE_CYCLES cycles -> Idle.
//   SigInt   : tx toggles 11,00,11,... every cycle starting with 11.
//  Timing: alert_req_i high in cycle t with FSM in Idle and no ping pending -> tx=10 in t+1.
//  Timing: ping toggle on alert_rx_i in cycle t -> tx=10 in t+2.
//  Timing: ack rise on alert_rx_i in cycle t -> tx=01 in t+2.
//  Integrity: sigint on either pair forces SigInt from any state and sets integ_fail_o
//   (same cycle as rx_q). Ping detection is frozen while in SigInt. On clean pairs -> Idle
//   the next cycle; ping_pend cleared, alert_pend kept.
//  New requests arriving during a handshake or pause are latched and served after Pause.
// CONFIGURATION
//  ALERT_SENDER_ASYNC_EN defined: alert_rx_i passes through a 2-flop synchronizer ahead of
//   rx_q. All rx-derived latencies grow by 2 cycles. A single-cycle p/n mismatch is tolerated;
//   sigint is asserted only when it persists >=2 cycles (skew filter).
//  ALERT_SENDER_ASYNC_EN undefined: single input register, no filter; sigint acts on the first
//   bad cycle.
// STRUCTURE
//  Package prim_alert_sync_pkg holds:
//   - state typedef (Idle, HsPh1, HsPh2, Pause, SigInt)
//   - rx/tx bit-index localparams
//   - TX_IDLE=2'b01 and RX_RESET=4'b0101 constants
//   The matching receiver reuses this package.
//  Sub-module prim_diff_decode_sync: per-pair register/sync, level and sigint (incl. skew filter
//   under the macro); instantiated twice (ping, ack).
// TESTING
//  1 alert_req_i 1-cycle pulse, receiver model acks after 3 cycles
//    -> tx 10 next cycle; 01 two cycles after ack rise; alert_ack_o pulses once when ack falls;
//       next handshake is not started for PAUSE_CYCLES.
//  2 ping toggle rx[3:2] 01->10
//    -> tx=10 two cycles later; full handshake with alert_ack_o never asserted.
//  3 ping toggle and alert_req_i in the same cycle
//    -> ping handshake first, alert handshake after Pause; exactly one alert_ack_o.
//  4 ack pair forced to 11 for 4 cycles mid HsPh1
//    -> integ_fail_o=1 for 4 cycles; tx toggles 11/00; then tx=01, Idle; pending alert re-sent.
//  5 rst_i asserted during HsPh1 with alert_pend=1
//    -> tx=01, alert_ack_o=0 next cycle; no handshake after release until a new request.
//  6 macro build: 1-cycle ack p/n skew
//    -> integ_fail_o stays 0; all latencies are +2 cycles versus scenarios 1-2.

Source files
------------

// File: rtl/prim_alert_sync_pkg.sv
// Shared encodings for the synchronous alert sender/receiver pair.
// States, rx/tx bit positions and the idle/reset wire values of the differential link.
package prim_alert_sync_pkg;

   typedef enum logic [2:0] {
      Idle   = 3'd0,
      HsPh1  = 3'd1,
      HsPh2  = 3'd2,
      Pause  = 3'd3,
      SigInt = 3'd4
   } state_e;

   localparam int unsigned RX_PING_P  = 3;
   localparam int unsigned RX_PING_N  = 2;
   localparam int unsigned RX_ACK_P   = 1;
   localparam int unsigned RX_ACK_N   = 0;
   localparam int unsigned TX_ALERT_P = 1;
   localparam int unsigned TX_ALERT_N = 0;

   localparam logic [1:0] TX_IDLE   = 2'b01;
   localparam logic [1:0] TX_HS     = 2'b10;
   localparam logic [1:0] TX_SIG_HI = 2'b11;
   localparam logic [3:0] RX_RESET  = 4'b0101;

endpackage

// File: rtl/prim_diff_decode_sync.sv
// Registers one differential pair and decodes level=p, sigint=(p==n); 1 cycle (3 with ALERT_SENDER_ASYNC_EN).
// No backpressure; under ALERT_SENDER_ASYNC_EN a lone mismatch cycle is treated as skew and filtered out.
module prim_diff_decode_sync #(
   parameter logic RESET_P = 1'b0,
   parameter logic RESET_N = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_diff_p,
   input  logic i_diff_n,
   output logic o_level,
   output logic o_sigint
);

   logic [1:0] r_q;
   logic       w_mis;

   assign w_mis   = (r_q[1] == r_q[0]);
   assign o_level = r_q[1];

`ifdef ALERT_SENDER_ASYNC_EN
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic       r_mis_prev;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync1    <= {RESET_P, RESET_N};
         r_sync2    <= {RESET_P, RESET_N};
         r_q        <= {RESET_P, RESET_N};
         r_mis_prev <= 1'b0;
      end else begin
         r_sync1    <= {i_diff_p, i_diff_n};
         r_sync2    <= r_sync1;
         r_q        <= r_sync2;
         r_mis_prev <= w_mis;
      end
   end

   // p and n may cross the synchronizer one cycle apart; only a persisting mismatch counts
   assign o_sigint = w_mis & r_mis_prev;
`else
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_q <= {RESET_P, RESET_N};
      end else begin
         r_q <= {i_diff_p, i_diff_n};
      end
   end

   assign o_sigint = w_mis;
`endif

endmodule

// File: rtl/prim_alert_sender_sync.sv
// Alert sender: alert requests and receiver ping toggles become the alert_p/alert_n 4-phase handshake.
// req->tx 1 cycle, rx->tx 2 cycles (+2 with ALERT_SENDER_ASYNC_EN); requests arriving while busy are latched.
module prim_alert_sender_sync
   import prim_alert_sync_pkg::*;
#(
   parameter int unsigned PAUSE_CYCLES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       alert_req_i,
   output logic       alert_ack_o,
   output logic       integ_fail_o,
   input  logic [3:0] alert_rx_i,
   output logic [1:0] alert_tx_o
);

   localparam int unsigned       CNT_W      = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);

   state_e           r_state;
   state_e           w_state_d;
   logic [1:0]       r_tx;
   logic [1:0]       w_tx_d;
   logic [CNT_W-1:0] r_pause_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_alert_pend;
   logic             r_ping_pend;
   logic             r_ping_prev;
   logic             r_is_alert;
   logic             r_ack;

   logic w_ping_level;
   logic w_ping_sigint;
   logic w_ack_level;
   logic w_ack_sigint;
   logic w_sigint;
   logic w_ping_evt;
   logic w_start;
   logic w_start_alert;
   logic w_ack_done;
   logic w_abort_alert;

   prim_diff_decode_sync #(
      .RESET_P (RX_RESET[RX_PING_P]),
      .RESET_N (RX_RESET[RX_PING_N])
   ) u_ping_dec (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_diff_p (alert_rx_i[RX_PING_P]),
      .i_diff_n (alert_rx_i[RX_PING_N]),
      .o_level  (w_ping_level),
      .o_sigint (w_ping_sigint)
   );

   prim_diff_decode_sync #(
      .RESET_P (RX_RESET[RX_ACK_P]),
      .RESET_N (RX_RESET[RX_ACK_N])
   ) u_ack_dec (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_diff_p (alert_rx_i[RX_ACK_P]),
      .i_diff_n (alert_rx_i[RX_ACK_N]),
      .o_level  (w_ack_level),
      .o_sigint (w_ack_sigint)
   );

   assign w_sigint   = w_ping_sigint | w_ack_sigint;
   assign w_ping_evt = !w_ping_sigint && (r_state != SigInt) && (w_ping_level != r_ping_prev);
   // An alert cut short by an integrity failure must be re-sent once the link is clean again
   assign w_abort_alert = w_sigint && r_is_alert && ((r_state == HsPh1) || (r_state == HsPh2));

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_pause_cnt;
      w_start       = 1'b0;
      w_start_alert = 1'b0;
      w_ack_done    = 1'b0;
      case (r_state)
         Idle: begin
            // Ping first so the receiver never takes a genuine alert for a ping reply
            if (r_ping_pend || w_ping_evt) begin
               w_state_d = HsPh1;
               w_start   = 1'b1;
            end else if (r_alert_pend || alert_req_i) begin
               w_state_d     = HsPh1;
               w_start       = 1'b1;
               w_start_alert = 1'b1;
            end
         end
         HsPh1: begin
            if (w_ack_level) begin
               w_state_d = HsPh2;
            end
         end
         HsPh2: begin
            if (!w_ack_level) begin
               w_state_d  = Pause;
               w_cnt_d    = '0;
               w_ack_done = r_is_alert;
            end
         end
         Pause: begin
            if (r_pause_cnt == PAUSE_LAST) begin
               w_state_d = Idle;
            end else begin
               w_cnt_d = r_pause_cnt + CNT_W'(1);
            end
         end
         SigInt: begin
            w_state_d = Idle;
         end
         default: begin
            w_state_d = Idle;
         end
      endcase

      if (w_sigint) begin
         w_state_d     = SigInt;
         w_start       = 1'b0;
         w_start_alert = 1'b0;
         w_ack_done    = 1'b0;
      end
   end

   // tx is registered from the next state so a request in Idle reaches the wire one cycle later
   always_comb begin
      w_tx_d = TX_IDLE;
      case (w_state_d)
         HsPh1:   w_tx_d = TX_HS;
         SigInt:  w_tx_d = (r_state == SigInt) ? {~r_tx[TX_ALERT_P], ~r_tx[TX_ALERT_N]} : TX_SIG_HI;
         default: w_tx_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= Idle;
         r_tx         <= TX_IDLE;
         r_pause_cnt  <= '0;
         r_alert_pend <= 1'b0;
         r_ping_pend  <= 1'b0;
         r_ping_prev  <= 1'b0;
         r_is_alert   <= 1'b0;
         r_ack        <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_tx        <= w_tx_d;
         r_pause_cnt <= w_cnt_d;
         r_ack       <= w_ack_done;
         if (w_start) begin
            r_is_alert <= w_start_alert;
         end
         if (w_start && w_start_alert) begin
            r_alert_pend <= 1'b0;
         end else begin
            r_alert_pend <= r_alert_pend | alert_req_i | w_abort_alert;
         end
         if ((w_state_d == SigInt) || (w_start && !w_start_alert)) begin
            r_ping_pend <= 1'b0;
         end else begin
            r_ping_pend <= r_ping_pend | w_ping_evt;
         end
         if (!w_ping_sigint && (r_state != SigInt)) begin
            r_ping_prev <= w_ping_level;
         end
      end
   end

   assign alert_tx_o   = r_tx;
   assign alert_ack_o  = r_ack;
   assign integ_fail_o = w_sigint;

endmodule

// File: tb/tb_prim_alert_sender_sync.sv
// Directed bench for prim_alert_sender_sync: the bench plays the alert receiver with hand-timed ping/ack edges.
// Inputs change and outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_prim_alert_sender_sync;

   localparam int unsigned PAUSE_CYCLES = 2;
`ifdef ALERT_SENDER_ASYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       alert_req_i;
   logic       alert_ack_o;
   logic       integ_fail_o;
   logic [3:0] alert_rx_i;
   logic [1:0] alert_tx_o;

   logic ping_lvl;
   logic ack_lvl;
   int   n_cmp   = 0;
   int   n_mis   = 0;
   int   ack_cnt = 0;
   int   ack_base;

   always #5 clk_i = ~clk_i;

   prim_alert_sender_sync #(
      .PAUSE_CYCLES (PAUSE_CYCLES)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .alert_req_i  (alert_req_i),
      .alert_ack_o  (alert_ack_o),
      .integ_fail_o (integ_fail_o),
      .alert_rx_i   (alert_rx_i),
      .alert_tx_o   (alert_tx_o)
   );

   always @(negedge clk_i) begin
      if (alert_ack_o === 1'b1) ack_cnt = ack_cnt + 1;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_rx();
      alert_rx_i = {ping_lvl, ~ping_lvl, ack_lvl, ~ack_lvl};
   endtask

   // Called in the cycle tx shows 10: raise ack, lower it once tx returns to 01, then ride out the pause.
   task automatic ack_hs(input logic exp_ack, input string tag);
      ack_lvl = 1'b1;
      drive_rx();
      repeat (LAT + 1) step();
      chk({tag, "_ph1_hold"}, {6'd0, alert_tx_o}, 8'h02);
      step();
      chk({tag, "_ph2_tx"}, {6'd0, alert_tx_o}, 8'h01);
      ack_lvl = 1'b0;
      drive_rx();
      repeat (LAT + 1) step();
      chk({tag, "_ack_early"}, {7'd0, alert_ack_o}, 8'h00);
      step();
      chk({tag, "_ack"}, {7'd0, alert_ack_o}, {7'd0, exp_ack});
      repeat (PAUSE_CYCLES) step();
      chk({tag, "_idle_tx"}, {6'd0, alert_tx_o}, 8'h01);
   endtask

   initial begin
      rst_i       = 1'b1;
      alert_req_i = 1'b0;
      ping_lvl    = 1'b0;
      ack_lvl     = 1'b0;
      drive_rx();
      repeat (3 + LAT) step();
      chk("rst_tx", {6'd0, alert_tx_o}, 8'h01);
      chk("rst_ack", {7'd0, alert_ack_o}, 8'h00);
      chk("rst_integ", {7'd0, integ_fail_o}, 8'h00);
      rst_i = 1'b0;
      step();
      chk("idle_tx", {6'd0, alert_tx_o}, 8'h01);

      // 1: alert pulse, second alert latched mid-handshake and served only after the pause
      ack_base    = ack_cnt;
      alert_req_i = 1'b1;
      step();
      alert_req_i = 1'b0;
      chk("s1_req_tx", {6'd0, alert_tx_o}, 8'h02);
      step();
      alert_req_i = 1'b1;
      step();
      alert_req_i = 1'b0;
      ack_hs(1'b1, "s1a");
      step();
      chk("s1_second_tx", {6'd0, alert_tx_o}, 8'h02);
      ack_hs(1'b1, "s1b");
      repeat (4) step();
      chk("s1_quiet_tx", {6'd0, alert_tx_o}, 8'h01);
      chk("s1_ack_count", 8'(ack_cnt - ack_base), 8'd2);

      // 2: ping toggle 01->10 answered two cycles later, never acked as an alert
      ack_base = ack_cnt;
      ping_lvl = 1'b1;
      drive_rx();
      repeat (LAT + 1) step();
      chk("s2_wait_tx", {6'd0, alert_tx_o}, 8'h01);
      step();
      chk("s2_ping_tx", {6'd0, alert_tx_o}, 8'h02);
      ack_hs(1'b0, "s2");
      chk("s2_ack_count", 8'(ack_cnt - ack_base), 8'd0);

      // 3: request lands in the cycle the ping toggle is seen; ping goes first
      ack_base = ack_cnt;
      ping_lvl = 1'b0;
      drive_rx();
      repeat (LAT + 1) step();
      alert_req_i = 1'b1;
      step();
      alert_req_i = 1'b0;
      chk("s3_ping_tx", {6'd0, alert_tx_o}, 8'h02);
      ack_hs(1'b0, "s3p");
      step();
      chk("s3_alert_tx", {6'd0, alert_tx_o}, 8'h02);
      ack_hs(1'b1, "s3a");
      repeat (4) step();
      chk("s3_quiet_tx", {6'd0, alert_tx_o}, 8'h01);
      chk("s3_ack_count", 8'(ack_cnt - ack_base), 8'd1);

`ifndef ALERT_SENDER_ASYNC_EN
      // 4: ack pair stuck at 11 for four cycles during HsPh1
      alert_req_i = 1'b1;
      step();
      alert_req_i = 1'b0;
      chk("s4_start_tx", {6'd0, alert_tx_o}, 8'h02);
      step();
      alert_rx_i[1:0] = 2'b11;
      step();
      chk("s4_integ_1", {7'd0, integ_fail_o}, 8'h01);
      chk("s4_tx_1", {6'd0, alert_tx_o}, 8'h02);
      step();
      chk("s4_integ_2", {7'd0, integ_fail_o}, 8'h01);
      chk("s4_tx_2", {6'd0, alert_tx_o}, 8'h03);
      step();
      chk("s4_integ_3", {7'd0, integ_fail_o}, 8'h01);
      chk("s4_tx_3", {6'd0, alert_tx_o}, 8'h00);
      step();
      chk("s4_integ_4", {7'd0, integ_fail_o}, 8'h01);
      chk("s4_tx_4", {6'd0, alert_tx_o}, 8'h03);
      ack_lvl = 1'b0;
      drive_rx();
      step();
      chk("s4_integ_clr", {7'd0, integ_fail_o}, 8'h00);
      chk("s4_tx_5", {6'd0, alert_tx_o}, 8'h00);
      step();
      chk("s4_idle_tx", {6'd0, alert_tx_o}, 8'h01);
      step();
      chk("s4_resend_tx", {6'd0, alert_tx_o}, 8'h02);
      ack_hs(1'b1, "s4");
`endif

      // 5: reset in HsPh1 with a second alert pending drops everything
      ack_base    = ack_cnt;
      alert_req_i = 1'b1;
      step();
      chk("s5_start_tx", {6'd0, alert_tx_o}, 8'h02);
      step();
      alert_req_i = 1'b0;
      rst_i       = 1'b1;
      step();
      chk("s5_rst_tx", {6'd0, alert_tx_o}, 8'h01);
      chk("s5_rst_ack", {7'd0, alert_ack_o}, 8'h00);
      rst_i = 1'b0;
      repeat (6) step();
      chk("s5_no_resend_tx", {6'd0, alert_tx_o}, 8'h01);
      alert_req_i = 1'b1;
      step();
      alert_req_i = 1'b0;
      chk("s5_new_tx", {6'd0, alert_tx_o}, 8'h02);
      ack_hs(1'b1, "s5");
      chk("s5_ack_count", 8'(ack_cnt - ack_base), 8'd1);

`ifdef ALERT_SENDER_ASYNC_EN
      // 6: ack_p rises one cycle before ack_n falls; skew must not flag an integrity failure
      alert_req_i = 1'b1;
      step();
      alert_req_i = 1'b0;
      chk("s6_start_tx", {6'd0, alert_tx_o}, 8'h02);
      alert_rx_i[1:0] = 2'b11;
      step();
      ack_lvl = 1'b1;
      drive_rx();
      chk("s6_integ_a", {7'd0, integ_fail_o}, 8'h00);
      step();
      chk("s6_integ_b", {7'd0, integ_fail_o}, 8'h00);
      step();
      chk("s6_integ_c", {7'd0, integ_fail_o}, 8'h00);
      chk("s6_hold_tx", {6'd0, alert_tx_o}, 8'h02);
      step();
      chk("s6_integ_d", {7'd0, integ_fail_o}, 8'h00);
      chk("s6_ph2_tx", {6'd0, alert_tx_o}, 8'h01);
      step();
      chk("s6_integ_e", {7'd0, integ_fail_o}, 8'h00);
      ack_lvl = 1'b0;
      drive_rx();
      repeat (LAT + 1) step();
      chk("s6_ack_early", {7'd0, alert_ack_o}, 8'h00);
      step();
      chk("s6_ack", {7'd0, alert_ack_o}, 8'h01);
      repeat (PAUSE_CYCLES) step();
      chk("s6_idle_tx", {6'd0, alert_tx_o}, 8'h01);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
